fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Instruction-fetch stage feeding the decoder. Owns the PC, issues in-order word reads on the
//  instruction bus, tags each returned word with its pc/pcplus4, and buffers entries in a FIFO.
//  Decode pops entries via valid/ready. Redirects (branch, jump, exception, eret) flush the stage
//  and discard stale bus responses.
// PARAMETERS
//  DEPTH      4              FIFO entries (power of 2, >=2)
//  MAX_OUTST  2              max bus requests accepted but not yet answered
//  RESET_PC   32'hbfc0_0000  PC after reset
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  reset          in   1   asynchronous, active-high reset
//  ireq_valid     out  1   read request valid
//  ireq_addr      out  32  read address (word aligned)
//  iresp_addr_ok  in   1   request accepted this cycle
//  iresp_data_ok  in   1   read data returned this cycle (in request order)
//  iresp_data     in   32  returned instruction word
//  redirect_valid in   1   flush and restart at redirect_pc
//  redirect_pc    in   32  new fetch PC
//  out_valid      out  1   FIFO head valid
//  out_ready      in   1   decode accepts head
//  out_raw_instr  out  32  head instruction (32'h0 when out_adel=1)
//  out_pc         out  32  head PC
//  out_pcplus4    out  32  head PC + 4 (mod 2^32)
//  out_adel       out  1   head is a misaligned-fetch exception entry
// BEHAVIOUR
//  Reset: pc=RESET_PC; FIFO empty; outst=0; drop=0; state=RUN; ireq_valid=0; out_valid=0;
//   all data outputs 0. Reset mid-transaction discards everything; later responses are not
//   absorbed; bench resets the bus model together with this block.
//  Counters: outst=accepted but unanswered (0..MAX_OUTST); drop=stale subset of outst; live=outst-drop.
//  FSM:
//   RUN:  ireq_valid=1, ireq_addr=pc when pc[1:0]==0, outst<MAX_OUTST, count+live<DEPTH.
//         On addr_ok: pc<=pc+4, outst++. ireq_valid=1 without addr_ok -> HOLD.
//         pc[1:0]!=0 and count<DEPTH: push {instr=0, pc, adel=1}, no bus request -> HALT.
//   HOLD: ireq_valid=1, ireq_addr held stable until addr_ok (also across redirects).
//         On addr_ok: outst++, pc<=pc+4, or count as stale if marked stale -> RUN.
//   HALT: no requests until redirect_valid.
//  Response: data_ok with drop>0 -> discard, drop--, outst--. Otherwise push
//   {iresp_data, resp_pc, adel=0}, resp_pc+=4, outst--. Live responses never overflow (space reserved).
//  Pop: out_valid && out_ready. Push+pop in the same cycle is allowed when full.
//   Head visible the cycle after push. FIFO pointers wrap modulo DEPTH.
//  Redirect (highest priority, effective this edge):
//   - FIFO cleared; a pop this cycle is ignored.
//   - pc<=redirect_pc; resp_pc<=redirect_pc.
//   - drop<=outst_next, counting a request accepted this edge; a data_ok this cycle is
//     discarded, never pushed.
//   - HOLD request marked stale and stays in HOLD; its pc update is suppressed.
//   - HALT/RUN -> RUN. Misaligned redirect_pc -> adel entry next cycle.
//  pc and pcplus4 arithmetic wraps at 32 bits. Output is 1 entry/cycle when the bus
//   returns 1 word/cycle.
// TESTING
//  1 Reset, 0-wait bus, out_ready=1 -> ireq_addr bfc00000,04,08; outputs in order,
//    out_pcplus4=pc+4; ireq_valid=0 during reset.
//  2 out_ready=0 -> exactly DEPTH=4 words accepted, then ireq_valid=0; ready=1 drains 4 words
//    in order, then fetch resumes at bfc00010.
//  3 Two reads outstanding, redirect to 80000100 -> both responses dropped; first output
//    pc=80000100 with matching data.
//  4 Redirect while HOLD at bfc00008 (addr_ok late) -> addr stays bfc00008 until addr_ok;
//    its data dropped; next addr 80000100.
//  5 Redirect to 80000102 -> no bus request; out_valid with out_adel=1, out_pc=80000102,
//    instr=0; stalls until next redirect.
//  6 Reset asserted mid-burst with 2 outstanding -> out_valid=0, ireq_valid=0 immediately;
//    after release fetch restarts at bfc00000.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order word reads on the
// instruction bus, tags returned words with pc/pcplus4 and buffers them in a
// FIFO that decode drains through out_valid/out_ready. A redirect flushes the
// FIFO and discards responses to requests issued before it.
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   ireq_valid, ireq_addr           read request (registered, word aligned)
//   iresp_addr_ok                   request accepted this cycle
//   iresp_data_ok, iresp_data       in-order read data
//   redirect_valid, redirect_pc     flush and restart fetch at redirect_pc
//   out_valid, out_ready            FIFO head handshake
//   out_raw_instr, out_pc,
//   out_pcplus4, out_adel           FIFO head payload
module fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_raw_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pcplus4,
    output logic        out_adel
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);
    localparam int unsigned SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);
    localparam logic [OUT_W-1:0] MAX_O   = OUT_W'(MAX_OUTST);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // Registered state
    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [OUT_W-1:0] outst_q, outst_d;
    logic [OUT_W-1:0] drop_q, drop_d;
    logic             hold_stale_q, hold_stale_d;
    logic             req_valid_q, req_valid_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] mem_instr [DEPTH];
    logic [31:0] mem_pc    [DEPTH];
    logic [31:0] mem_pcp4  [DEPTH];
    logic        mem_adel  [DEPTH];

    // Per-cycle events
    logic             accept;
    logic             resp;
    logic             resp_live;
    logic             pop;
    logic             push;
    logic [31:0]      push_instr;
    logic [31:0]      push_pc;
    logic             push_adel;
    logic             adel_push;
    logic             drop_inc;
    logic [OUT_W-1:0] live_d;
    logic [SUM_W-1:0] occ_d;

    // Bus and handshake events; a response with nothing outstanding is ignored
    assign accept    = req_valid_q & iresp_addr_ok;
    assign resp      = iresp_data_ok & (outst_q != '0);
    assign resp_live = resp & (drop_q == '0) & ~redirect_valid;
    assign pop       = (count_q != '0) & out_ready & ~redirect_valid;

    // Next-state, FIFO bookkeeping and next request
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        resp_pc_d    = resp_pc_q;
        hold_stale_d = 1'b0;
        drop_inc     = 1'b0;
        adel_push    = 1'b0;
        push         = 1'b0;
        push_instr   = '0;
        push_pc      = '0;
        push_adel    = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        req_valid_d  = 1'b0;
        req_addr_d   = pc_q;
        live_d       = '0;
        occ_d        = '0;
        outst_d      = outst_q + OUT_W'(accept) - OUT_W'(resp);

        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    pc_d = pc_q + 32'd4;
                end else if (req_valid_q) begin
                    state_d = ST_HOLD;
                end else if ((pc_q[1:0] != 2'b00) && (count_q < DEPTH_C) && !resp_live) begin
                    adel_push = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    state_d = ST_RUN;
                    // A stale request's response is dropped and must not move the PC
                    if (hold_stale_q) begin
                        drop_inc = 1'b1;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        drop_d = drop_q - OUT_W'(resp && (drop_q != '0)) + OUT_W'(drop_inc);

        if (resp_live) begin
            push       = 1'b1;
            push_instr = iresp_data;
            push_pc    = resp_pc_q;
            resp_pc_d  = resp_pc_q + 32'd4;
        end else if (adel_push) begin
            push      = 1'b1;
            push_pc   = pc_q;
            push_adel = 1'b1;
        end

        // Redirect overrides everything; every request still on the bus becomes stale
        if (redirect_valid) begin
            pc_d      = redirect_pc;
            resp_pc_d = redirect_pc;
            drop_d    = outst_d;
            push      = 1'b0;
            state_d   = ((state_q == ST_HOLD) && !accept) ? ST_HOLD : ST_RUN;
        end

        hold_stale_d = (state_d == ST_HOLD) && (hold_stale_q || redirect_valid);

        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        // Live responses always have a FIFO slot reserved before the request issues
        live_d = outst_d - drop_d;
        occ_d  = SUM_W'(count_d) + SUM_W'(live_d);

        case (state_d)
            ST_HOLD: begin
                req_valid_d = 1'b1;
                req_addr_d  = req_addr_q;
            end
            ST_RUN: begin
                req_valid_d = (pc_d[1:0] == 2'b00) && (outst_d < MAX_O) && (occ_d < DEPTH_S);
                req_addr_d  = pc_d;
            end
            default: begin
                req_valid_d = 1'b0;
                req_addr_d  = pc_d;
            end
        endcase
    end

    // State and control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            outst_q      <= '0;
            drop_q       <= '0;
            hold_stale_q <= 1'b0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            resp_pc_q    <= resp_pc_d;
            outst_q      <= outst_d;
            drop_q       <= drop_d;
            hold_stale_q <= hold_stale_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage; cleared on reset so the head payload reads as zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
                mem_pcp4[i]  <= '0;
                mem_adel[i]  <= 1'b0;
            end
        end else if (push) begin
            mem_instr[wr_ptr_q] <= push_instr;
            mem_pc[wr_ptr_q]    <= push_pc;
            mem_pcp4[wr_ptr_q]  <= push_pc + 32'd4;
            mem_adel[wr_ptr_q]  <= push_adel;
        end
    end

    assign ireq_valid    = req_valid_q;
    assign ireq_addr     = req_addr_q;
    assign out_valid     = (count_q != '0);
    assign out_raw_instr = mem_instr[rd_ptr_q];
    assign out_pc        = mem_pc[rd_ptr_q];
    assign out_pcplus4   = mem_pcp4[rd_ptr_q];
    assign out_adel      = mem_adel[rd_ptr_q];

endmodule
